// File: rtl/read_arbiter_core.sv
// read_arbiter_core
//   Picks which priority queue of one output port is read next. Two
//   modes, selected by sp0_wrr1 and sampled only while idle:
//     0 = strict priority: the highest-index nonempty queue wins.
//     1 = weighted round robin: each queue owns a credit counter, which is
//         loaded from its weight and spent one per accepted grant. A
//         rotating pointer picks the first eligible queue at or after it.
//
//   A grant is offered in GRANT and never withdrawn. It moves to SERVE when
//   the read engine accepts it, and goes back to IDLE when the engine
//   signals end of packet.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   sp0_wrr1     mode select (0 strict priority, 1 weighted round robin)
//   q_nonempty   one bit per queue, 1 = at least one complete packet
//   weights      WRR weight of queue i in [(i+1)*WEIGHT_W-1 : i*WEIGHT_W]
//   rd_ready     read engine accepts the offered grant this cycle
//   eop          read engine finished the granted packet (1-cycle pulse)
//   grant_valid  grant_q is valid and offered (GRANT state)
//   grant_q      granted queue index
//   busy         a granted packet is being read (SERVE state)
//   dbg_state    current FSM state (0 IDLE, 1 GRANT, 2 SERVE)
//
// grant_q and the pointer are 3 bits wide, so NUM_QUEUES must not exceed 8.
//
// Handshake: grant_valid/grant_q form a valid/ready pair with rd_ready.
//   A transfer happens on a rising edge where grant_valid && rd_ready are
//   both 1. Once grant_valid is raised, it and grant_q stay constant until
//   that transfer. rd_ready is a don't-care while grant_valid is 0, and
//   eop is a don't-care outside SERVE.

module read_arbiter_core #(
  parameter int NUM_QUEUES = 8,
  parameter int WEIGHT_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sp0_wrr1,
  input  logic [NUM_QUEUES-1:0]          q_nonempty,
  input  logic [NUM_QUEUES*WEIGHT_W-1:0] weights,
  input  logic                           rd_ready,
  input  logic                           eop,
  output logic                           grant_valid,
  output logic [2:0]                     grant_q,
  output logic                           busy,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SERVE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Mode latched at the last idle decision. A difference from sp0_wrr1
  // while idle is a mode change.
  logic mode_q;

  // WRR round-robin pointer and per-queue credits.
  logic [2:0]          ptr;
  logic [WEIGHT_W-1:0] credit [NUM_QUEUES];

  // Selection candidates
  logic [NUM_QUEUES-1:0] eligible;
  logic [2:0]            sp_pick;
  logic [2:0]            wrr_pick;
  logic                  wrr_found;
  logic [3:0]            scan_idx;

  // FSM strobes into the datapath registers
  logic       load_grant;
  logic [2:0] grant_nxt;
  logic       do_reload;
  logic       do_dec;
  logic       ptr_load;
  logic [2:0] ptr_nxt;
  logic       mode_load;

  // ------------------------------------------------------------------
  // Candidate selection
  // ------------------------------------------------------------------

  // Strict priority: a later (higher) index overrides an earlier one.
  always_comb begin
    sp_pick = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (q_nonempty[i]) begin
        sp_pick = 3'(i);
      end
    end
  end

  // A queue takes part in WRR only with a packet waiting and credit left.
  // A zero weight reloads to zero credit, which keeps that queue out.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      eligible[i] = q_nonempty[i] && (credit[i] != '0);
    end
  end

  // Scan upward from the pointer and wrap at NUM_QUEUES. The first
  // eligible queue found wins.
  always_comb begin
    wrr_pick  = '0;
    wrr_found = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_QUEUES; k++) begin
      scan_idx = {1'b0, ptr} + 4'(k);
      if (scan_idx >= 4'(NUM_QUEUES)) begin
        scan_idx = scan_idx - 4'(NUM_QUEUES);
      end
      if (!wrr_found && eligible[scan_idx[2:0]]) begin
        wrr_found = 1'b1;
        wrr_pick  = scan_idx[2:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and datapath strobes
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    load_grant = 1'b0;
    grant_nxt  = grant_q;
    do_reload  = 1'b0;
    do_dec     = 1'b0;
    ptr_load   = 1'b0;
    ptr_nxt    = ptr;
    mode_load  = 1'b0;

    unique case (state)
      IDLE: begin
        if (sp0_wrr1 != mode_q) begin
          // On a mode change, restart WRR from a clean slate. The
          // selection waits one cycle so it sees the reloaded credits.
          mode_load = 1'b1;
          do_reload = 1'b1;
          ptr_load  = 1'b1;
          ptr_nxt   = '0;
        end else if (!sp0_wrr1) begin
          if (|q_nonempty) begin
            load_grant = 1'b1;
            grant_nxt  = sp_pick;
            state_nxt  = GRANT;
          end
        end else if (wrr_found) begin
          load_grant = 1'b1;
          grant_nxt  = wrr_pick;
          state_nxt  = GRANT;
        end else if (|q_nonempty) begin
          // Work is waiting but every credit is spent. Refill now and
          // select next cycle. If all waiting queues have weight 0, this
          // repeats every cycle and no grant is ever made.
          do_reload = 1'b1;
        end
      end

      GRANT: begin
        if (rd_ready) begin
          state_nxt = SERVE;
          if (mode_q) begin
            // The granted queue had credit > 0 when it was chosen, and
            // credits cannot change in GRANT, so this never underflows.
            do_dec   = 1'b1;
            ptr_load = 1'b1;
            if (credit[grant_q] > WEIGHT_W'(1)) begin
              ptr_nxt = grant_q;
            end else if (grant_q == 3'(NUM_QUEUES - 1)) begin
              ptr_nxt = '0;
            end else begin
              ptr_nxt = grant_q + 3'd1;
            end
          end
        end
      end

      SERVE: begin
        if (eop) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr     <= '0;
      mode_q  <= 1'b0;
    end else begin
      if (load_grant) begin
        grant_q <= grant_nxt;
      end
      if (ptr_load) begin
        ptr <= ptr_nxt;
      end
      if (mode_load) begin
        mode_q <= sp0_wrr1;
      end
    end
  end

  // Credits reset to zero, so the first WRR decision always starts with a
  // reload from the weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        credit[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_QUEUES; i++) begin
        if (do_reload) begin
          credit[i] <= weights[i*WEIGHT_W +: WEIGHT_W];
        end else if (do_dec && (grant_q == 3'(i))) begin
          credit[i] <= credit[i] - WEIGHT_W'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs. These decode the registered state, so reset clears them
  // without waiting for a clock edge.
  // ------------------------------------------------------------------
  assign grant_valid = (state == GRANT);
  assign busy        = (state == SERVE);
  assign dbg_state   = state;

endmodule

// File: tb/tb_read_arbiter_core.sv
// Bench for read_arbiter_core.
// Stimulus is a list of phases. Each phase holds one configuration (mode,
// q_nonempty, weights) steady and asks for a number of packets. A reference
// model works out the grant order for each phase from the arbitration rules
// and queues it. A negedge monitor pops the queue and compares on every
// accepted grant, and also checks the hold and busy behaviour around each
// handshake.

module tb_read_arbiter_core;

  localparam int NQ  = 8;
  localparam int WW  = 4;
  localparam int NPH = 40;

  // ---------------- clock / reset / DUT ----------------
  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          sp0_wrr1   = 1'b0;
  logic [NQ-1:0] q_nonempty = '0;
  logic [NQ*WW-1:0] weights = '0;
  logic          rd_ready   = 1'b0;
  logic          eop        = 1'b0;
  logic          grant_valid;
  logic [2:0]    grant_q;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  read_arbiter_core #(.NUM_QUEUES(NQ), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sp0_wrr1    (sp0_wrr1),
    .q_nonempty  (q_nonempty),
    .weights     (weights),
    .rd_ready    (rd_ready),
    .eop         (eop),
    .grant_valid (grant_valid),
    .grant_q     (grant_q),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  // phase configurations; entry NPH is the quiet end-of-run setting
  bit          c_mode [NPH+1];
  logic [7:0]  c_qne  [NPH+1];
  logic [31:0] c_w    [NPH+1];
  int          c_n    [NPH+1];
  bit          c_rst  [NPH+1];

  // reference model state
  int m_cred [NQ];
  int m_ptr;
  bit m_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic int wnib(input logic [31:0] w, input int i);
    return int'(w[i*WW +: WW]);
  endfunction

  task automatic apply_cfg(input int k);
    sp0_wrr1   = c_mode[k];
    q_nonempty = c_qne[k];
    weights    = c_w[k];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) m_cred[i] = 0;
    m_ptr  = 0;
    m_mode = 1'b0;
  endtask

  task automatic model_reload(input int k);
    for (int i = 0; i < NQ; i++) m_cred[i] = wnib(c_w[k], i);
  endtask

  // first queue at/after the pointer with a packet and credit left
  function automatic int model_find(input int k);
    for (int off = 0; off < NQ; off++) begin
      int i = (m_ptr + off) % NQ;
      if (c_qne[k][i] && m_cred[i] > 0) return i;
    end
    return -1;
  endfunction

  // Works out the grants phase k produces and queues them. got is how many
  // grants actually happen; it may be fewer than asked for when WRR runs
  // out of usable weight.
  task automatic model_phase(input int k, output int got);
    int pick;
    int saved [NQ];
    got = 0;
    if (c_mode[k] != m_mode) begin
      m_mode = c_mode[k];
      model_reload(k);
      m_ptr = 0;
    end
    if (!m_mode) begin
      pick = -1;
      for (int i = NQ - 1; i >= 0; i--) begin
        if (c_qne[k][i]) begin
          pick = i;
          break;
        end
      end
      if (pick >= 0) begin
        for (int g = 0; g < c_n[k]; g++) exp_q.push_back(3'(pick));
        got = c_n[k];
      end
      return;
    end
    for (int g = 0; g < c_n[k]; g++) begin
      pick = model_find(k);
      if (pick < 0 && c_qne[k] != 0) begin
        saved = m_cred;
        model_reload(k);
        pick = model_find(k);
        // If grants were already made, the next configuration arrives
        // during the last SERVE, so the dead-end reload never happens.
        if (pick < 0 && g > 0) m_cred = saved;
      end
      if (pick < 0) break;
      exp_q.push_back(3'(pick));
      m_cred[pick] = m_cred[pick] - 1;
      m_ptr = (m_cred[pick] > 0) ? pick : (pick + 1) % NQ;
      got++;
    end
  endtask

  // ---------------- monitor ----------------
  bit         prev_hold = 1'b0;
  bit         prev_acc  = 1'b0;
  logic [2:0] prev_gq   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        check("hold_valid", 32'(grant_valid), 32'd1);
        check("hold_grant_q", 32'(grant_q), 32'(prev_gq));
      end
      if (prev_acc) begin
        check("busy_after_accept", 32'(busy), 32'd1);
        check("valid_drop_after_accept", 32'(grant_valid), 32'd0);
      end
      if (grant_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_grant: got grant_q=%0d, expected no grant (t=%0t)", grant_q, $time);
        end else begin
          check("grant_q", 32'(grant_q), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = grant_valid && !rd_ready;
      prev_acc  = grant_valid && rd_ready;
      prev_gq   = grant_q;
    end else begin
      prev_hold = 1'b0;
      prev_acc  = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant();
    int cnt = 0;
    @(negedge clk);
    while (!grant_valid) begin
      cnt++;
      if (cnt > 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_timeout: got no grant_valid in 40 cycles, expected a grant (t=%0t)", $time);
        finish_run();
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int next_k);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_valid", 32'(grant_valid), 32'd0);
    check("rst_grant_q", 32'(grant_q), 32'd0);
    model_reset();
    apply_cfg(next_k);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_grant", 32'(grant_valid), 32'd1);
  endtask

  // one packet: offer, accept after 0..5 cycles, serve for 1..4 cycles
  task automatic do_grant(input int k, input bit last);
    int d;
    int s;
    d = $urandom_range(0, 5);
    rd_ready = (d == 0);
    wait_grant();
    if (d > 0) begin
      repeat (d - 1) begin
        @(posedge clk);
        #1;
        eop = ($urandom_range(0, 2) == 0);  // stray eop while offering
      end
      @(posedge clk);
      #1;
      eop      = 1'b0;
      rd_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    if (last) begin
      if (c_rst[k]) begin
        do_reset(k + 1);
        return;
      end
      apply_cfg(k + 1);
    end
    s = $urandom_range(0, 3);
    repeat (s) begin
      @(posedge clk);
      #1;
    end
    eop = 1'b1;
    @(posedge clk);
    #1;
    eop = 1'b0;
  endtask

  task automatic run_phase(input int k);
    int got;
    model_phase(k, got);
    if (got == 0) begin
      repeat (20) begin
        @(negedge clk);
        check("no_grant", 32'(grant_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      apply_cfg(k + 1);
    end else begin
      for (int g = 0; g < got; g++) do_grant(k, g == got - 1);
    end
  endtask

  task automatic build_cfg();
    for (int k = 0; k <= NPH; k++) begin
      c_mode[k] = 1'($urandom_range(0, 1));
      c_qne[k]  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int i = 0; i < NQ; i++) c_w[k][i*WW +: WW] = 4'($urandom_range(0, 3));
      c_n[k]    = $urandom_range(1, 8);
      c_rst[k]  = ($urandom_range(0, 9) == 0);
    end
    // strict priority, 0b0010_0101 -> 5 every packet
    c_mode[0] = 1'b0; c_qne[0] = 8'b0010_0101; c_w[0] = 32'h0;         c_n[0] = 4; c_rst[0] = 1'b0;
    // WRR q0=2 q1=1 -> 0,0,1,0,0,1
    c_mode[1] = 1'b1; c_qne[1] = 8'h03;        c_w[1] = 32'h0000_0012; c_n[1] = 6; c_rst[1] = 1'b0;
    // wrap through queue 7 with all weights 1
    c_mode[2] = 1'b1; c_qne[2] = 8'h81;        c_w[2] = 32'h1111_1111; c_n[2] = 4; c_rst[2] = 1'b0;
    // zero weight on the only waiting queue -> no grant
    c_mode[3] = 1'b1; c_qne[3] = 8'h04;        c_w[3] = 32'h1111_1011; c_n[3] = 3; c_rst[3] = 1'b0;
    // back to strict priority -> queue 2; then reset while serving
    c_mode[4] = 1'b0; c_qne[4] = 8'h04;        c_w[4] = 32'h1111_1011; c_n[4] = 2; c_rst[4] = 1'b1;
    c_mode[5] = 1'b1; c_qne[5] = 8'h3C;        c_w[5] = 32'h0021_3200; c_n[5] = 8; c_rst[5] = 1'b0;
    // after a reset there must be something to grant straight away
    for (int k = 6; k < NPH; k++) begin
      if (c_rst[k-1]) begin
        c_qne[k] = c_qne[k] | 8'h01;
        if (c_w[k][3:0] == 4'd0) c_w[k][3:0] = 4'd1;
      end
    end
    c_rst[NPH-1] = 1'b0;
    c_qne[NPH]   = 8'h00;
    c_mode[NPH]  = c_mode[NPH-1];
  endtask

  // ---------------- main sequence ----------------
  initial begin
    build_cfg();
    model_reset();
    apply_cfg(0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant_valid", 32'(grant_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant_q", 32'(grant_q), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < NPH; k++) run_phase(k);
    repeat (10) @(negedge clk);
    check("final_idle", 32'(grant_valid), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    finish_run();
  end

  initial begin
    #2_000_000;
    n_cmp++;
    n_err++;
    $display("FAIL watchdog: got simulation still running, expected completion");
    finish_run();
  end

endmodule
